// File: rtl/riscv_md_pkg.sv
// Shared RV32M multiply/divide definitions: operation codes, FSM states, widths.
package riscv_md_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    // Remainder ops share funct3[1]=1 among the divide group.
    function automatic logic md_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module md_sign_fix
    import riscv_md_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    always_comb begin
        res_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, registered result and done pulse.
module mdu_iterative
    import riscv_md_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      MDCode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MDResult
);

    localparam int unsigned CW = $clog2(ITER + 1);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    md_op_e            op_in;
    logic              a_signed, b_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              b_zero, div_ovf, special_in;
    logic [XLEN-1:0]   special_val;
    logic              neg_in;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_part, div_trial;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   final_res;

    assign op_in    = md_op_e'(MDCode);
    assign a_signed = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign b_signed = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};

    md_sign_fix #(.W(XLEN)) u_abs_a (
        .val_i (A),
        .neg_i (a_signed & A[XLEN-1]),
        .res_o (a_mag)
    );

    md_sign_fix #(.W(XLEN)) u_abs_b (
        .val_i (B),
        .neg_i (b_signed & B[XLEN-1]),
        .res_o (b_mag)
    );

    // Divide-by-zero and signed overflow are resolved at issue and skip the iterations.
    always_comb begin
        b_zero      = (B == '0);
        div_ovf     = (op_in == MD_DIV || op_in == MD_REM) &&
                      (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        special_in  = md_is_div(op_in) && (b_zero || div_ovf);
        special_val = '0;
        if (b_zero) begin
            special_val = md_is_rem(op_in) ? A : '1;
        end else if (!md_is_rem(op_in)) begin
            special_val = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        neg_in = 1'b0;
        unique case (op_in)
            MD_MUL, MD_MULH, MD_DIV: neg_in = A[XLEN-1] ^ B[XLEN-1];
            MD_MULHSU, MD_REM:       neg_in = A[XLEN-1];
            default:                 neg_in = 1'b0;
        endcase
    end

    // Multiply: acc = {partial, multiplier}, add multiplicand to the top half then shift right.
    // Divide: acc = {remainder, dividend/quotient}, shift left with a 33-bit trial subtract.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_part  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_part - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step      = md_is_div(op_q) ? div_next : mul_next;
        fix_in    = step;
        if (md_is_div(op_q)) begin
            fix_in = {{XLEN{1'b0}}, (md_is_rem(op_q) ? step[2*XLEN-1:XLEN] : step[XLEN-1:0])};
        end
    end

    md_sign_fix #(.W(2*XLEN)) u_res_fix (
        .val_i (fix_in),
        .neg_i (neg_q),
        .res_o (fix_out)
    );

    assign final_res = (op_q == MD_MUL || md_is_div(op_q)) ? fix_out[XLEN-1:0]
                                                            : fix_out[2*XLEN-1:XLEN];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        res_d      = res_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d       = op_in;
                    neg_d      = neg_in;
                    spec_d     = special_in;
                    spec_res_d = special_val;
                    cnt_d      = '0;
                    if (md_is_div(op_in)) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (spec_q) begin
                    res_d   = spec_res_q;
                    state_d = S_DONE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        res_d   = final_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= MD_MUL;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign MDResult = res_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus pushes expected result and completion cycle, monitor pops on done.
module tb_mdu_iterative;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  MDCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] MDResult;

    mdu_iterative #(.XLEN(32), .ITER(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MDCode   (MDCode),
        .A        (A),
        .B        (B),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .MDResult (MDResult)
    );

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned nchk;
    int unsigned npass;
    int unsigned ndone;
    logic [31:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                ndone++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_result"}, MDResult, e.res);
                    chk({e.name, "_done_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_done(input string name, input int unsigned lat, input int unsigned pre_busy);
        int unsigned nb;
        bit          seen;
        nb   = pre_busy;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
                break;
            end
            if (busy) nb++;
        end
        if (!seen) chk({name, "_timeout"}, 32'(done), 32'd1);
        chk({name, "_busy_cycles"}, nb, lat);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned lat, input string name);
        int unsigned pb;
        @(negedge clk);
        MDCode = op; A = a; B = b; start = 1'b1;
        sb.push_back('{exp, cyc + 1 + lat, name});
        @(negedge clk);
        start = 1'b0;
        MDCode = ~op; A = ~a; B = b ^ 32'h5A5A_0001;
        pb = busy ? 1 : 0;
        wait_done(name, lat, pb);
        last_res = exp;
    endtask

    initial begin
        int unsigned d0;
        nchk = 0; npass = 0; ndone = 0; last_res = '0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; MDCode = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", MDResult, 32'd0);

        issue(3'b000, 32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFF9, 32, "mul_neg1x7");
        issue(3'b000, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFF4, 32, "mul_3xm4");
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulh_min");
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulhu_min");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu_m1");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu_max");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32, "rem_m7_2");
        issue(3'b101, 32'd100,       32'd7,        32'd14,        32, "divu_100_7");
        issue(3'b111, 32'd100,       32'd7,        32'd2,         32, "remu_100_7");
        issue(3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 1,  "divu_by0");
        issue(3'b110, 32'd5,         32'd0,        32'd5,         1,  "rem_by0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

        // Flush a DIV mid-flight: no done, result keeps the previous value.
        @(negedge clk);
        MDCode = 3'b100; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result_held", MDResult, last_res);
        issue(3'b101, 32'd1000, 32'd3, 32'd333, 32, "divu_after_flush");

        // Reset in the middle of a MUL.
        @(negedge clk);
        MDCode = 3'b000; A = 32'd9; B = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", MDResult, 32'd0);

        // Start held high while busy: exactly one completion.
        @(negedge clk);
        d0 = ndone;
        MDCode = 3'b000; A = 32'd6; B = 32'd7; start = 1'b1;
        sb.push_back('{32'd42, cyc + 33, "mul_held_start"});
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) chk("held_start_timeout", 32'(done), 32'd1);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_start_done_count", ndone - d0, 32'd1);
        chk("held_start_idle_busy", 32'(busy), 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
